// File: rtl/risc_v_mike_mmio_timer_if.sv
// MMIO bus between the memory controller (master) and the timer (slave).
interface risc_v_mike_mmio_timer_if;
    logic [31:0] data_mmio_addr;
    logic        data_mmio_sel;
    logic        data_mmio_wr_addr_val;
    logic [31:0] data_mmio_wr_data;
    logic [31:0] data_mmio_rd_data;

    modport master (
        output data_mmio_addr,
        output data_mmio_sel,
        output data_mmio_wr_addr_val,
        output data_mmio_wr_data,
        input  data_mmio_rd_data
    );

    modport slave (
        input  data_mmio_addr,
        input  data_mmio_sel,
        input  data_mmio_wr_addr_val,
        input  data_mmio_wr_data,
        output data_mmio_rd_data
    );
endinterface

// File: rtl/risc_v_mike_mmio_timer.sv
// MMIO timer: prescaler, 32-bit up-counter, compare with sticky MATCH and auto-reload.
// Define MIKE_TIMER_IRQ_EN to add CTRL.IRQ_EN and the timer_irq output.
module risc_v_mike_mmio_timer #(
    parameter int unsigned PRESCALE_W  = 16,
    parameter logic [31:0] COMPARE_RST = 32'hFFFF_FFFF
) (
    input  logic clk,
    input  logic rst,
    risc_v_mike_mmio_timer_if.slave bus
`ifdef MIKE_TIMER_IRQ_EN
    ,
    output logic timer_irq
`endif
);
    localparam int unsigned DATA_W = 32;
`ifdef MIKE_TIMER_IRQ_EN
    localparam int unsigned CTRL_W = 3;
`else
    localparam int unsigned CTRL_W = 2;
`endif
    localparam int unsigned CTRL_EN = 0;
    localparam int unsigned CTRL_AR = 1;

    localparam logic [2:0] OFF_CTRL     = 3'd0;
    localparam logic [2:0] OFF_PRESCALE = 3'd1;
    localparam logic [2:0] OFF_COUNT    = 3'd2;
    localparam logic [2:0] OFF_COMPARE  = 3'd3;
    localparam logic [2:0] OFF_STATUS   = 3'd4;

    logic [CTRL_W-1:0]     ctrl_q, ctrl_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
    logic [DATA_W-1:0]     count_q, count_d;
    logic [DATA_W-1:0]     compare_q, compare_d;
    logic                  match_q, match_d;

    logic [2:0]        off_c;
    logic              wr_c;
    logic [DATA_W-1:0] wdata_c;
    logic              tick_c;
    logic              hit_c;
    logic              unused_addr_bits;

    assign off_c   = bus.data_mmio_addr[4:2];
    assign wr_c    = bus.data_mmio_wr_addr_val;
    assign wdata_c = bus.data_mmio_wr_data;
    assign unused_addr_bits = ^{bus.data_mmio_addr[31:5], bus.data_mmio_addr[1:0]};

    // Counting first, then bus writes override (COUNT write beats a tick),
    // then a match sets MATCH after any W1C so set wins.
    always_comb begin
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        pcnt_d     = pcnt_q;
        count_d    = count_q;
        compare_d  = compare_q;
        match_d    = match_q;

        tick_c = ctrl_q[CTRL_EN] && (pcnt_q == prescale_q);
        hit_c  = tick_c && (count_q == compare_q);

        if (ctrl_q[CTRL_EN]) begin
            pcnt_d = tick_c ? '0 : pcnt_q + PRESCALE_W'(1);
        end

        if (tick_c) begin
            count_d = (hit_c && ctrl_q[CTRL_AR]) ? '0 : count_q + DATA_W'(1);
        end

        if (wr_c) begin
            unique case (off_c)
                OFF_CTRL:     ctrl_d = wdata_c[CTRL_W-1:0];
                OFF_PRESCALE: begin
                    prescale_d = wdata_c[PRESCALE_W-1:0];
                    pcnt_d     = '0;
                end
                OFF_COUNT:    count_d   = wdata_c;
                OFF_COMPARE:  compare_d = wdata_c;
                OFF_STATUS:   if (wdata_c[0]) match_d = 1'b0;
                default:      ;
            endcase
        end

        if (hit_c) begin
            match_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q     <= '0;
            prescale_q <= '0;
            pcnt_q     <= '0;
            count_q    <= '0;
            compare_q  <= COMPARE_RST;
            match_q    <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            match_q    <= match_d;
        end
    end

`ifdef MIKE_TIMER_IRQ_EN
    // Registered from the next-state values so it rises on the matching edge.
    logic irq_q, irq_d;

    always_comb begin
        irq_d = match_d & ctrl_d[2];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign timer_irq = irq_q;
`endif

    // Combinational read mux; reserved offsets and deselect read zero.
    always_comb begin
        bus.data_mmio_rd_data = '0;
        if (bus.data_mmio_sel) begin
            unique case (off_c)
                OFF_CTRL:     bus.data_mmio_rd_data = DATA_W'(ctrl_q);
                OFF_PRESCALE: bus.data_mmio_rd_data = DATA_W'(prescale_q);
                OFF_COUNT:    bus.data_mmio_rd_data = count_q;
                OFF_COMPARE:  bus.data_mmio_rd_data = compare_q;
                OFF_STATUS:   bus.data_mmio_rd_data = DATA_W'(match_q);
                default:      bus.data_mmio_rd_data = '0;
            endcase
        end
    end
endmodule

// File: doc/risc_v_mike_mmio_timer.md
# risc_v_mike_mmio_timer

Memory-mapped timer peripheral that responds to the core's MMIO bus accesses, the responder side of the load/store path that the multicycle core drives through the memory controller's MMIO window. It has a programmable prescaler, a 32-bit up-counter, a compare register with a sticky match flag and optional auto-reload, and an optional interrupt output. It sits next to `risc_v_mike_gpio_module`, shares its address/data/write-valid bus, and returns read data to the core's memory-data register.

## Interface
Parameters:
- `PRESCALE_W`, default 16: width of the PRESCALE register and of the internal prescale counter.
- `COMPARE_RST`, default 32'hFFFFFFFF: reset value of COMPARE.

Ports:
- `clk`, input, 1: the single clock.
- `rst`, input, 1: asynchronous, active-low reset.
- `data_mmio_addr`, input, 32: MMIO address from the memory controller. Only bits [4:2] are decoded.
- `data_mmio_sel`, input, 1: the timer's window is selected (the memory controller's read-valid for this range).
- `data_mmio_wr_addr_val`, input, 1: write strobe, already qualified by the memory-write enable.
- `data_mmio_wr_data`, input, 32: store data (register-file read port 2).
- `data_mmio_rd_data`, output, 32: combinational read data.
- `timer_irq`, output, 1: interrupt request. Present only with `MIKE_TIMER_IRQ_EN`.

## Operation
Register map. The offset is `data_mmio_addr[4:2]`; all registers are 32-bit words.
- 0x00 CTRL: bit0 EN, bit1 AUTORELOAD, bit2 IRQ_EN. Other bits read 0.
- 0x04 PRESCALE: bits [PRESCALE_W-1:0]. Upper bits read 0.
- 0x08 COUNT: read/write.
- 0x0C COMPARE: read/write.
- 0x10 STATUS: bit0 MATCH, sticky. Writing 1 clears it; writing 0 has no effect.
- 0x14–0x1C: reserved. Reads return 0; writes are ignored.

Bus behaviour:
- Write: registered at the rising edge of `clk` when `data_mmio_wr_addr_val` = 1.
- Read: `data_mmio_rd_data` = selected register when `data_mmio_sel` = 1, otherwise 0. Reads have no side effects.

Counting:
- Internal prescale counter `pcnt`, PRESCALE_W bits. While EN = 1:
  - if `pcnt` == PRESCALE, then `pcnt` ← 0 and a tick is generated;
  - otherwise `pcnt` ← `pcnt` + 1.
- While EN = 0, `pcnt` and COUNT hold.
- On a tick:
  - if COUNT == COMPARE: MATCH ← 1, and COUNT ← 0 if AUTORELOAD = 1, else COUNT ← COUNT + 1;
  - otherwise COUNT ← COUNT + 1.
  - The increment wraps from 32'hFFFFFFFF to 0 with no flag.
- With AUTORELOAD = 1 the match period is (COMPARE+1)·(PRESCALE+1) cycles.
- `timer_irq` = MATCH & IRQ_EN. It is level-type and cleared by a W1C write to STATUS.

Simultaneous events:
- A COUNT write and a tick in the same cycle: the write wins.
- A PRESCALE write forces `pcnt` ← 0 in the same edge.
- A STATUS W1C and a new match in the same cycle: set wins, MATCH stays 1.
- A COMPARE write takes effect on the next tick evaluation.
- Writing CTRL.EN from 0 to 1 does not reset `pcnt`.

## Timing
- Reset values (asynchronous, while `rst` = 0):
  - CTRL = 0, PRESCALE = 0, COUNT = 0, COMPARE = `COMPARE_RST`, STATUS = 0, `pcnt` = 0;
  - `timer_irq` = 0;
  - `data_mmio_rd_data` follows the register values, so it reads 0 except for COMPARE.
- Reset asserted mid-count returns every register to its reset value immediately. The first tick after release needs EN to be written first.
- Write latency: a written value is visible on a read in the next cycle.
- Read latency: 0 cycles (combinational). The core captures it in its memory-data register at the following edge.
- Tick-to-flag: MATCH and `timer_irq` rise on the same edge that processes the matching tick.
- With PRESCALE = 0, a tick occurs every cycle while EN = 1.

## Configuration
- `MIKE_TIMER_IRQ_EN` defined:
  - the `timer_irq` port exists;
  - CTRL.IRQ_EN is writable and readable;
  - `timer_irq` = MATCH & IRQ_EN.
- Not defined:
  - no `timer_irq` port;
  - CTRL bit2 is not stored and reads 0;
  - MATCH remains pollable through STATUS.

## Test plan
- Reset: hold `rst` = 0 mid-count with EN = 1. Expected: COUNT reads 0, COMPARE reads 32'hFFFFFFFF, STATUS reads 0, `timer_irq` = 0.
- Prescale: PRESCALE = 3, COUNT = 0, CTRL = 1. Expected: after 40 cycles COUNT = 10, and COUNT changes only every 4th cycle.
- Auto-reload: PRESCALE = 0, COMPARE = 4, CTRL = 3. Expected: COUNT sequence 0,1,2,3,4,0,1…; MATCH set on the first wrap to 0; period 5 cycles.
- Interrupt (`MIKE_TIMER_IRQ_EN`):
  - CTRL = 7, COMPARE = 2. Expected: `timer_irq` rises 3 cycles after enable.
  - Write STATUS = 1. Expected: `timer_irq` drops the next cycle.
  - Repeat the W1C on the exact match cycle. Expected: MATCH stays 1.
- Collisions and wrap:
  - COUNT write 32'h55 on a tick cycle. Expected: COUNT = 32'h55.
  - COUNT = 32'hFFFFFFFF, AUTORELOAD = 0, COMPARE = 7. Expected: COUNT wraps to 0 with MATCH unchanged.
- Reserved and deselected reads:
  - write to 0x18, then read it. Expected: 0, and no other register changed;
  - `data_mmio_sel` = 0. Expected: `data_mmio_rd_data` = 0.
